// File: rtl/counter_mod_updown.sv
// ----------------------------------------------------------------------------
// counter_mod_updown
//
// Parametrised modulo counter with up, down, bounce and one-shot modes.
// Supports a synchronous load, a count enable, a one-cycle terminal-count
// pulse, a direction flag and a sticky one-shot done flag. All outputs are
// registered.
//
// Optional feature macro: COUNTER_PRESCALE_EN
//   defined   : an internal prescaler counts enabled cycles 0..PRESCALE-1 and
//               a step is taken only when it reaches PRESCALE-1.
//   undefined : every enabled cycle is a step; PRESCALE is ignored and no
//               prescaler register exists.
//
// Parameters
//   WIDTH    : bit width of q and load_val
//   MODULUS  : count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   PRESCALE : enabled cycles per step (prescaler build only), >= 1
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous reset, active-high
//   en       in   1      count enable; low holds all counting state
//   load     in   1      synchronous load of load_val (clamped to MODULUS-1)
//   load_val in   WIDTH  load value
//   mode     in   2      00 UP, 01 DOWN, 10 BOUNCE, 11 ONESHOT
//   q        out  WIDTH  registered count
//   tc       out  1      terminal-count pulse, one cycle after the step
//   dir      out  1      current direction, 0 = up, 1 = down
//   done     out  1      one-shot complete, sticky until load or rst
// ----------------------------------------------------------------------------
module counter_mod_updown #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             dir,
    output logic             done
);

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Terminal values are computed at elaboration in integer arithmetic and
    // then narrowed, so MODULUS == 2**WIDTH still yields an all-ones maximum
    // without needing a WIDTH+1 bit compare.
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAXM1_V = WIDTH'(MODULUS - 2);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             dir_r;
    logic             done_r;

    logic [WIDTH-1:0] q_step_s;
    logic             dir_step_s;
    logic             done_step_s;
    logic             tc_step_s;
    logic             step_s;

    // Load values above the range saturate at the top of the range; since
    // MAX_V is the largest legal value, "> MAX_V" is the same as ">= MODULUS".
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if (val > MAX_V) begin
            res = MAX_V;
        end else begin
            res = val;
        end
        return res;
    endfunction

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);

    logic [PW-1:0] pre_r;

    // Prescaler: counts enabled cycles; restarts on rst and load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= {PW{1'b0}};
        end else if (load) begin
            pre_r <= {PW{1'b0}};
        end else if (en) begin
            if (pre_r == PRE_MAX) begin
                pre_r <= {PW{1'b0}};
            end else begin
                pre_r <= pre_r + PRE_ONE;
            end
        end else begin
            pre_r <= pre_r;
        end
    end

    assign step_s = en & (pre_r == PRE_MAX);
`else
    assign step_s = en;
`endif

    // Next-state of one counting step for the currently selected mode.
    always_comb begin
        q_step_s    = q_r;
        dir_step_s  = dir_r;
        done_step_s = done_r;
        tc_step_s   = 1'b0;
        case (mode)
            MODE_UP: begin
                dir_step_s = 1'b0;
                if (q_r == MAX_V) begin
                    q_step_s  = ZERO_V;
                    tc_step_s = 1'b1;
                end else begin
                    q_step_s = q_r + ONE_V;
                end
            end
            MODE_DOWN: begin
                dir_step_s = 1'b1;
                if (q_r == ZERO_V) begin
                    q_step_s  = MAX_V;
                    tc_step_s = 1'b1;
                end else begin
                    q_step_s = q_r - ONE_V;
                end
            end
            MODE_BOUNCE: begin
                // Direction is inherited from whatever mode ran before, so a
                // switch into bounce continues the current sweep.
                if (dir_r == 1'b0) begin
                    if (q_r == MAX_V) begin
                        q_step_s   = MAXM1_V;
                        dir_step_s = 1'b1;
                        tc_step_s  = 1'b1;
                    end else begin
                        q_step_s   = q_r + ONE_V;
                        dir_step_s = 1'b0;
                    end
                end else begin
                    if (q_r == ZERO_V) begin
                        q_step_s   = ONE_V;
                        dir_step_s = 1'b0;
                        tc_step_s  = 1'b1;
                    end else begin
                        q_step_s   = q_r - ONE_V;
                        dir_step_s = 1'b1;
                    end
                end
            end
            MODE_ONESHOT: begin
                dir_step_s = 1'b0;
                if (done_r) begin
                    q_step_s = q_r;
                end else if (q_r == MAX_V) begin
                    // Already parked at the top (e.g. loaded there): finish
                    // without a pulse, since no step into the top occurred.
                    q_step_s    = q_r;
                    done_step_s = 1'b1;
                end else begin
                    q_step_s = q_r + ONE_V;
                    if ((q_r + ONE_V) == MAX_V) begin
                        done_step_s = 1'b1;
                        tc_step_s   = 1'b1;
                    end else begin
                        done_step_s = 1'b0;
                    end
                end
            end
            default: begin
                q_step_s    = q_r;
                dir_step_s  = dir_r;
                done_step_s = done_r;
                tc_step_s   = 1'b0;
            end
        endcase
    end

    // Output registers: rst beats load, load beats a step; tc is a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= ZERO_V;
            tc_r   <= 1'b0;
            dir_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (load) begin
            q_r    <= clamp_load(load_val);
            tc_r   <= 1'b0;
            dir_r  <= (mode == MODE_DOWN) ? 1'b1 : 1'b0;
            done_r <= 1'b0;
        end else if (step_s) begin
            q_r    <= q_step_s;
            tc_r   <= tc_step_s;
            dir_r  <= dir_step_s;
            done_r <= done_step_s;
        end else begin
            q_r    <= q_r;
            tc_r   <= 1'b0;
            dir_r  <= dir_r;
            done_r <= done_r;
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign dir  = dir_r;
    assign done = done_r;

endmodule

// File: tb/tb_counter_mod_updown.sv
// ----------------------------------------------------------------------------
// tb_counter_mod_updown
//
// Directed bench for counter_mod_updown. A table of {inputs, expected outputs}
// records drives a MODULUS=10 instance; short hand-written sequences cover a
// MODULUS=16 instance (full-range wrap) and a PRESCALE=4 instance.
// ----------------------------------------------------------------------------
module tb_counter_mod_updown;

    localparam logic [1:0] UP = 2'b00;
    localparam logic [1:0] DN = 2'b01;
    localparam logic [1:0] BO = 2'b10;
    localparam logic [1:0] OS = 2'b11;

    typedef struct {
        string      name;
        logic       rst;
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic [1:0] mode;
        logic [3:0] q;
        logic       tc;
        logic       dir;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: MODULUS=10, one step per enabled cycle in either build.
    logic       a_rst, a_load, a_en;
    logic [3:0] a_lv, a_q;
    logic [1:0] a_mode;
    logic       a_tc, a_dir, a_done;

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut (
        .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .load_val(a_lv),
        .mode(a_mode), .q(a_q), .tc(a_tc), .dir(a_dir), .done(a_done));

    // Instance B: MODULUS=16 = 2**WIDTH.
    logic       b_rst, b_load, b_en;
    logic [3:0] b_lv, b_q;
    logic [1:0] b_mode;
    logic       b_tc, b_dir, b_done;

    counter_mod_updown #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) d16 (
        .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .load_val(b_lv),
        .mode(b_mode), .q(b_q), .tc(b_tc), .dir(b_dir), .done(b_done));

    // Instance C: PRESCALE=4.
    logic       c_rst, c_load, c_en;
    logic [3:0] c_lv, c_q;
    logic [1:0] c_mode;
    logic       c_tc, c_dir, c_done;

    counter_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dps (
        .clk(clk), .rst(c_rst), .en(c_en), .load(c_load), .load_val(c_lv),
        .mode(c_mode), .q(c_q), .tc(c_tc), .dir(c_dir), .done(c_done));

    vec_t vecs[$];

    function automatic void add(string nm, logic r, logic l, logic [3:0] lv,
                                logic e, logic [1:0] m, logic [3:0] eq,
                                logic etc, logic edir, logic edone);
        vec_t v;
        v.name = nm; v.rst = r; v.load = l; v.load_val = lv; v.en = e;
        v.mode = m; v.q = eq; v.tc = etc; v.dir = edir; v.done = edone;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic apply_a(vec_t v, int idx);
        @(negedge clk);
        a_rst = v.rst; a_load = v.load; a_lv = v.load_val; a_en = v.en; a_mode = v.mode;
        @(posedge clk);
        #1;
        check({v.name, ".q"},    idx, 32'(a_q),    32'(v.q));
        check({v.name, ".tc"},   idx, 32'(a_tc),   32'(v.tc));
        check({v.name, ".dir"},  idx, 32'(a_dir),  32'(v.dir));
        check({v.name, ".done"}, idx, 32'(a_done), 32'(v.done));
    endtask

    task automatic cyc_b(logic r, logic l, logic [3:0] lv, logic e, logic [1:0] m,
                         string nm, logic [3:0] eq, logic etc, logic edir);
        @(negedge clk);
        b_rst = r; b_load = l; b_lv = lv; b_en = e; b_mode = m;
        @(posedge clk);
        #1;
        check({nm, ".q"},   0, 32'(b_q),   32'(eq));
        check({nm, ".tc"},  0, 32'(b_tc),  32'(etc));
        check({nm, ".dir"}, 0, 32'(b_dir), 32'(edir));
    endtask

    task automatic cyc_c(logic r, logic l, logic [3:0] lv, logic e,
                         string nm, int idx, logic [3:0] eq);
        @(negedge clk);
        c_rst = r; c_load = l; c_lv = lv; c_en = e; c_mode = UP;
        @(posedge clk);
        #1;
        check({nm, ".q"}, idx, 32'(c_q), 32'(eq));
    endtask

    initial begin
        a_rst = 1'b1; a_load = 1'b0; a_lv = 4'd0; a_en = 1'b0; a_mode = UP;
        b_rst = 1'b1; b_load = 1'b0; b_lv = 4'd0; b_en = 1'b0; b_mode = UP;
        c_rst = 1'b1; c_load = 1'b0; c_lv = 4'd0; c_en = 1'b0; c_mode = UP;

        // ---- vector table for instance A (MODULUS=10) ----
        // UP from reset: wrap 9 -> 0 gives tc.
        add("rst", 1, 0, 0, 0, UP, 0, 0, 0, 0);
        add("rst", 1, 0, 0, 0, UP, 0, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 1, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 2, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 3, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 4, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 5, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 6, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 7, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 8, 0, 0, 0);
        add("up", 0, 0, 0, 1, UP, 9, 0, 0, 0);
        add("up_wrap", 0, 0, 0, 1, UP, 0, 1, 0, 0);
        add("up", 0, 0, 0, 1, UP, 1, 0, 0, 0);
        // DOWN after load 2: wrap 0 -> 9 gives tc.
        add("ld2", 0, 1, 2, 0, DN, 2, 0, 1, 0);
        add("dn", 0, 0, 0, 1, DN, 1, 0, 1, 0);
        add("dn", 0, 0, 0, 1, DN, 0, 0, 1, 0);
        add("dn_wrap", 0, 0, 0, 1, DN, 9, 1, 1, 0);
        add("dn", 0, 0, 0, 1, DN, 8, 0, 1, 0);
        add("hold", 0, 0, 0, 0, DN, 8, 0, 1, 0);
        // BOUNCE from reset.
        add("rst_b", 1, 0, 0, 0, BO, 0, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 1, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 2, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 3, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 4, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 5, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 6, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 7, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 8, 0, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 9, 0, 0, 0);
        add("bo_top", 0, 0, 0, 1, BO, 8, 1, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 7, 0, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 6, 0, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 5, 0, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 4, 0, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 3, 0, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 2, 0, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 1, 0, 1, 0);
        add("bo", 0, 0, 0, 1, BO, 0, 0, 1, 0);
        add("bo_bot", 0, 0, 0, 1, BO, 1, 1, 0, 0);
        add("bo", 0, 0, 0, 1, BO, 2, 0, 0, 0);
        // ONESHOT from 7: done at 9, then holds; load clears done.
        add("ld7", 0, 1, 7, 0, OS, 7, 0, 0, 0);
        add("os", 0, 0, 0, 1, OS, 8, 0, 0, 0);
        add("os_end", 0, 0, 0, 1, OS, 9, 1, 0, 1);
        add("os_hold", 0, 0, 0, 1, OS, 9, 0, 0, 1);
        add("os_hold", 0, 0, 0, 1, OS, 9, 0, 0, 1);
        add("ld3", 0, 1, 3, 0, OS, 3, 0, 0, 0);
        // Mode change mid-count: q kept, BOUNCE inherits dir=1.
        add("mc_dn", 0, 0, 0, 1, DN, 2, 0, 1, 0);
        add("mc_bo", 0, 0, 0, 1, BO, 1, 0, 1, 0);
        add("mc_hold", 0, 0, 0, 0, BO, 1, 0, 1, 0);
        add("mc_bo", 0, 0, 0, 1, BO, 0, 0, 1, 0);
        add("mc_bo_rev", 0, 0, 0, 1, BO, 1, 1, 0, 0);
        // done survives mode changes.
        add("ld8", 0, 1, 8, 0, OS, 8, 0, 0, 0);
        add("os_end2", 0, 0, 0, 1, OS, 9, 1, 0, 1);
        add("sticky", 0, 0, 0, 0, UP, 9, 0, 0, 1);
        add("sticky_wrap", 0, 0, 0, 1, UP, 0, 1, 0, 1);
        add("sticky_up", 0, 0, 0, 1, UP, 1, 0, 0, 1);
        add("sticky_os", 0, 0, 0, 1, OS, 1, 0, 0, 1);
        // rst beats load and en; load clamps; load beats en.
        add("rst_all", 1, 1, 5, 1, UP, 0, 0, 0, 0);
        add("ld12", 0, 1, 12, 0, UP, 9, 0, 0, 0);
        add("ld_en", 0, 1, 4, 1, UP, 4, 0, 0, 0);
        add("up5", 0, 0, 0, 1, UP, 5, 0, 0, 0);
        add("ld9dn", 0, 1, 9, 0, DN, 9, 0, 1, 0);
        add("ld0bo", 0, 1, 0, 0, BO, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_a(vecs[i], i);
        end

        // ---- instance B: MODULUS=16, full-range wrap ----
        cyc_b(1, 0, 0, 0, UP, "b_rst", 0, 0, 0);
        cyc_b(0, 1, 14, 0, UP, "b_ld14", 14, 0, 0);
        cyc_b(0, 0, 0, 1, UP, "b_up", 15, 0, 0);
        cyc_b(0, 0, 0, 1, UP, "b_wrap", 0, 1, 0);
        cyc_b(0, 0, 0, 1, UP, "b_up", 1, 0, 0);
        cyc_b(0, 0, 0, 1, DN, "b_dn", 0, 0, 1);
        cyc_b(0, 0, 0, 1, DN, "b_dnwrap", 15, 1, 1);
        cyc_b(0, 1, 15, 0, UP, "b_ld15", 15, 0, 0);
        cyc_b(0, 0, 0, 1, BO, "b_botop", 14, 1, 1);

        // ---- instance C: PRESCALE=4 ----
        cyc_c(1, 0, 0, 0, "c_rst", 0, 0);
`ifdef COUNTER_PRESCALE_EN
        cyc_c(0, 0, 0, 1, "c_pre", 1, 0);
        cyc_c(0, 0, 0, 1, "c_pre", 2, 0);
        cyc_c(0, 0, 0, 1, "c_pre", 3, 0);
        cyc_c(0, 0, 0, 1, "c_pre", 4, 1);
        cyc_c(0, 0, 0, 1, "c_pre", 5, 1);
        cyc_c(0, 0, 0, 1, "c_pre", 6, 1);
        cyc_c(0, 0, 0, 1, "c_pre", 7, 1);
        cyc_c(0, 0, 0, 1, "c_pre", 8, 2);
        cyc_c(0, 0, 0, 1, "c_pre", 9, 2);
        cyc_c(0, 0, 0, 1, "c_pre", 10, 2);
        cyc_c(0, 0, 0, 0, "c_gap", 11, 2);
        cyc_c(0, 0, 0, 0, "c_gap", 12, 2);
        cyc_c(0, 0, 0, 0, "c_gap", 13, 2);
        cyc_c(0, 0, 0, 1, "c_phase", 14, 2);
        cyc_c(0, 0, 0, 1, "c_phase", 15, 3);
        cyc_c(0, 1, 5, 1, "c_ld", 16, 5);
        cyc_c(0, 0, 0, 1, "c_restart", 17, 5);
        cyc_c(0, 0, 0, 1, "c_restart", 18, 5);
        cyc_c(0, 0, 0, 1, "c_restart", 19, 5);
        cyc_c(0, 0, 0, 1, "c_restart", 20, 6);
`else
        cyc_c(0, 0, 0, 1, "c_step", 1, 1);
        cyc_c(0, 0, 0, 1, "c_step", 2, 2);
        cyc_c(0, 0, 0, 1, "c_step", 3, 3);
        cyc_c(0, 0, 0, 0, "c_hold", 4, 3);
        cyc_c(0, 1, 5, 1, "c_ld", 5, 5);
        cyc_c(0, 0, 0, 1, "c_step", 6, 6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
